// File: rtl/audio_pkg.sv
// Shared types, constants and helpers for the soft-mute channel-strip block.
package audio_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic [16:0] gain_t;

  localparam gain_t GAIN_UNITY = 17'd32768;

  typedef enum logic [1:0] {
    UNMUTED,
    RAMP_DOWN,
    MUTED,
    RAMP_UP
  } mute_state_t;

  // Per-sample gain increment; a zero-length ramp becomes a single full-scale jump.
  function automatic int unsigned ramp_step(input int unsigned samples, input int unsigned frac);
    if (samples == 0) begin
      return 32'd1 << frac;
    end
    return ((32'd1 << frac) + samples - 32'd1) / samples;
  endfunction

endpackage

// File: rtl/gain_ramp.sv
// Mute FSM and linear gain register: ramps G between 0 and unity, reversing on any mute change.
module gain_ramp
  import audio_pkg::*;
#(
  parameter int unsigned RAMP_SAMPLES = 48,
  parameter int unsigned GAIN_FRAC    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mute,
  output logic [GAIN_FRAC+1:0] gain
);

  localparam int unsigned GW = GAIN_FRAC + 2;
  localparam logic [GW-1:0] UNITY = GW'(1) << GAIN_FRAC;
  localparam logic [GW-1:0] STEP  = GW'(ramp_step(RAMP_SAMPLES, GAIN_FRAC));

  mute_state_t   state_q, state_d;
  logic [GW-1:0] gain_q, gain_d;
  logic [GW-1:0] gain_dn, gain_up;

  // Saturating step in each direction; with a hard mute STEP equals unity.
  always_comb begin
    gain_dn = (gain_q > STEP) ? (gain_q - STEP) : '0;
    gain_up = (gain_q >= (UNITY - STEP)) ? UNITY : (gain_q + STEP);
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    unique case (state_q)
      UNMUTED, MUTED, RAMP_DOWN, RAMP_UP: begin
        if (mute && (state_q != MUTED)) begin
          gain_d  = gain_dn;
          state_d = (gain_dn == '0) ? MUTED : RAMP_DOWN;
        end else if (!mute && (state_q != UNMUTED)) begin
          gain_d  = gain_up;
          state_d = (gain_up == UNITY) ? UNMUTED : RAMP_UP;
        end
      end
      default: begin
        state_d = UNMUTED;
        gain_d  = UNITY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNMUTED;
      gain_q  <= UNITY;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  assign gain = gain_q;

endmodule

// File: rtl/audio_mute.sv
// Click-free soft mute: sample x gain with round-half-up, registered output, one clock latency.
module audio_mute
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned RAMP_SAMPLES = 48,
  parameter int unsigned GAIN_FRAC    = 15
) (
  input  logic                    clk_48,
  input  logic                    reset,
  input  logic                    mute,
  input  logic signed [WIDTH-1:0] muteIn,
  output logic signed [WIDTH-1:0] muteOut
);

  localparam int unsigned GW = GAIN_FRAC + 2;
  localparam int unsigned PW = WIDTH + GAIN_FRAC + 4;
  localparam logic [PW-1:0] RND = PW'(1) << (GAIN_FRAC - 1);

  logic [GW-1:0] gain;
  logic [PW-1:0] in_ext, gain_ext, prod, rounded;
  logic          unused_bits;

  gain_ramp #(
    .RAMP_SAMPLES(RAMP_SAMPLES),
    .GAIN_FRAC   (GAIN_FRAC)
  ) u_gain_ramp (
    .clk (clk_48),
    .rst (reset),
    .mute(mute),
    .gain(gain)
  );

  // Low PW bits of the product are the same for signed and unsigned operands.
  always_comb begin
    in_ext   = {{(PW - WIDTH){muteIn[WIDTH-1]}}, muteIn};
    gain_ext = {{(PW - GW){1'b0}}, gain};
    prod     = in_ext * gain_ext;
    rounded  = prod + RND;
  end

  // G never exceeds unity, so the slice after the shift cannot overflow.
  assign unused_bits = ^{rounded[PW-1:GAIN_FRAC+WIDTH], rounded[GAIN_FRAC-1:0]};

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      muteOut <= '0;
    end else begin
      muteOut <= rounded[GAIN_FRAC +: WIDTH];
    end
  end

endmodule

// File: tb/tb_audio_mute.sv
// Self-checking bench for audio_mute: vector table, hand corner sequences, random vs gain model.
module tb_audio_mute;

  localparam int UNITY = 32768;
  localparam int STEP  = 683;

  logic               clk_48 = 1'b0;
  logic               reset  = 1'b1;
  logic               mute   = 1'b0;
  logic               mute2  = 1'b0;
  logic signed [15:0] din    = '0;
  logic signed [15:0] din2   = '0;
  logic signed [15:0] dout, dout2;

  int tests = 0;
  int fails = 0;
  int g     = UNITY;
  int g2    = UNITY;
  int prev_in, prev_out;

  typedef struct {
    bit m;
    int x;
    int exp;
  } vec_t;
  vec_t vecs[10];

  audio_mute #(.WIDTH(16), .RAMP_SAMPLES(48), .GAIN_FRAC(15)) dut (
    .clk_48 (clk_48),
    .reset  (reset),
    .mute   (mute),
    .muteIn (din),
    .muteOut(dout)
  );

  audio_mute #(.WIDTH(16), .RAMP_SAMPLES(0), .GAIN_FRAC(15)) dut_hard (
    .clk_48 (clk_48),
    .reset  (reset),
    .mute   (mute2),
    .muteIn (din2),
    .muteOut(dout2)
  );

  always #5 clk_48 = ~clk_48;

  function automatic int next_gain(input int cur, input bit m, input int st);
    if (m) return (cur > st) ? cur - st : 0;
    return (cur + st >= UNITY) ? UNITY : cur + st;
  endfunction

  function automatic int scaled(input int x, input int gain);
    longint p;
    p = longint'(x) * longint'(gain) + 64'sd16384;
    p = p >>> 15;
    return int'(p);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One sample clock for both instances; the model predicts from pre-edge gain.
  task automatic step(input bit m, input int x, input bit m2, input int x2);
    int e1, e2;
    mute  = m;
    din   = 16'(x);
    mute2 = m2;
    din2  = 16'(x2);
    e1 = scaled(x, g);
    e2 = scaled(x2, g2);
    g  = next_gain(g, m, STEP);
    g2 = next_gain(g2, m2, UNITY);
    @(posedge clk_48);
    #1;
    check("model_soft", int'(dout), e1);
    check("model_hard", int'(dout2), e2);
  endtask

  function automatic int rnd_sample();
    return int'($signed(16'($urandom)));
  endfunction

  initial begin
    int x, e;
    vecs[0] = '{1'b0, 16384, 16384};
    vecs[1] = '{1'b0, 32767, 32767};
    vecs[2] = '{1'b0, -32768, -32768};
    vecs[3] = '{1'b1, 16384, 16384};
    vecs[4] = '{1'b1, 16384, 16043};
    vecs[5] = '{1'b1, 16384, 15701};
    vecs[6] = '{1'b0, 16384, 15360};
    vecs[7] = '{1'b0, -16384, -15701};
    vecs[8] = '{1'b0, 1000, 979};
    vecs[9] = '{1'b0, 1000, 1000};

    din  = 16'sd16384;
    din2 = 16'sd16384;
    repeat (3) @(posedge clk_48);
    #1;
    check("reset_out", int'(dout), 0);
    check("reset_out_hard", int'(dout2), 0);
    #3 reset = 1'b0;
    @(negedge clk_48);

    // Vector table from unity gain
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].m, vecs[i].x, 1'b0, vecs[i].x);
      check($sformatf("vec%0d", i), int'(dout), vecs[i].exp);
    end

    // Full ramp-down: zero first appears on the 49th edge, then holds
    prev_out = 16384;
    for (int k = 1; k <= 52; k++) begin
      step(1'b1, 16384, 1'b0, rnd_sample());
      if (k == 1) check("ramp_first", int'(dout), 16384);
      if (k == 2) check("ramp_second", int'(dout), 16043);
      if (k == 48) check("ramp_edge48", int'(dout), 334);
      if (k >= 49) check("ramp_zero", int'(dout), 0);
      if (int'(dout) > prev_out) check("ramp_monotonic", int'(dout), prev_out);
      prev_out = int'(dout);
    end

    // Sine while muted, then unmute and expect exact 1-clock pass-through after 48 edges
    for (int k = 0; k < 48; k++) begin
      x = $rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * k / 48.0) + 0.5));
      step(1'b1, x, 1'b0, x);
      check("sine_muted", int'(dout), 0);
    end
    for (int k = 1; k <= 96; k++) begin
      x = $rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * k / 48.0) + 0.5));
      step(1'b0, x, 1'b0, x);
      if (k >= 49) check("sine_pass", int'(dout), x);
    end

    // Reverse 10 edges into a ramp-down; no jumps beyond one step
    prev_out = 16384;
    for (int k = 1; k <= 21; k++) begin
      step((k <= 10), 16384, 1'b0, 16384);
      e = int'(dout) - prev_out;
      if (e < 0) e = -e;
      if (e > 342) check("reverse_jump", e, 342);
      prev_out = int'(dout);
    end
    check("reverse_gain", g, UNITY);
    check("reverse_out", int'(dout), 16384);

    // Async reset between edges during a ramp
    for (int k = 0; k < 5; k++) step(1'b1, 12000, 1'b1, 12000);
    #2 reset = 1'b1;
    #1;
    check("async_reset", int'(dout), 0);
    check("async_reset_hard", int'(dout2), 0);
    @(posedge clk_48);
    #2 reset = 1'b0;
    g  = UNITY;
    g2 = UNITY;
    step(1'b0, 1000, 1'b0, 1000);
    check("post_reset", int'(dout), 1000);
    check("post_reset_hard", int'(dout2), 1000);

    // Hard mute: first sampling edge still uses unity, zero from the second
    step(1'b0, 0, 1'b1, 5000);
    check("hard_mute_e1", int'(dout2), 5000);
    step(1'b0, 0, 1'b1, -7000);
    check("hard_mute_e2", int'(dout2), 0);
    step(1'b0, 0, 1'b0, 5000);
    check("hard_unmute_e1", int'(dout2), 0);
    step(1'b0, 0, 1'b0, -32768);
    check("hard_unmute_e2", int'(dout2), -32768);

    // Random stimulus with frequent mute toggles
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) mute = ~mute;
      if ($urandom_range(0, 5) == 0) mute2 = ~mute2;
      step(mute, rnd_sample(), mute2, rnd_sample());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
